// File: rtl/tt_proj_mux_ctrl_if.sv
// Bundle between the project-select controller and its surroundings: select
// port, user I/O, and the broadcast/return buses to the project wrappers.
interface tt_proj_mux_ctrl_if #(
    parameter int unsigned N_PROJ = 16,
    parameter int unsigned ADDR_W = 4
);
    localparam int unsigned OW_W = 24;

    logic                     sel_shift;
    logic                     sel_data;
    logic                     sel_load;
    logic                     usr_clk;
    logic                     usr_rst_n;
    logic [7:0]               ui_in;
    logic [7:0]               uio_in;
    logic [17:0]              iw;
    logic [N_PROJ-1:0]        ena;
    logic [OW_W*N_PROJ-1:0]   ow_flat;
    logic [7:0]               uo_out;
    logic [7:0]               uio_out;
    logic [7:0]               uio_oe;
    logic [ADDR_W-1:0]        cur_addr;
    logic                     busy;

    modport master (
        output sel_shift, sel_data, sel_load, usr_clk, usr_rst_n, ui_in, uio_in, ow_flat,
        input  iw, ena, uo_out, uio_out, uio_oe, cur_addr, busy
    );

    modport slave (
        input  sel_shift, sel_data, sel_load, usr_clk, usr_rst_n, ui_in, uio_in, ow_flat,
        output iw, ena, uo_out, uio_out, uio_oe, cur_addr, busy
    );
endinterface

// File: rtl/tt_proj_mux_ctrl.sv
// Project-select controller: serial address load, guarded disable/reset/run
// switching of the one-hot ena vector, iw broadcast and registered ow return mux.
module tt_proj_mux_ctrl #(
    parameter int unsigned N_PROJ       = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned RST_CYCLES   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    tt_proj_mux_ctrl_if.slave    bus
);
    localparam int unsigned OW_W    = 24;
    localparam int unsigned CNT_MAX = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GUARD  = 2'd1,
        ST_RESET  = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   sr_q;
    logic [N_PROJ-1:0]   ena_q, ena_d;
    logic                busy_q, busy_d;
    logic [OW_W-1:0]     out_q, out_d;
    logic [N_PROJ-1:0]   sel_onehot;
    logic [OW_W-1:0]     sel_ow;
    logic                in_range;
    logic                load_ok;
    logic                proj_on;
    logic [17:0]         iw_c;

    // Address decode; an out-of-range address leaves the one-hot vector empty
    always_comb begin
        sel_onehot = '0;
        sel_ow     = '0;
        for (int unsigned k = 0; k < N_PROJ; k++) begin
            if (addr_q == ADDR_W'(k)) begin
                sel_onehot[k] = 1'b1;
                sel_ow        = sel_ow | bus.ow_flat[OW_W*k +: OW_W];
            end
        end
        in_range = |sel_onehot;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic; loads are only honoured outside a switch in progress
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        load_ok = bus.sel_load && ((state_q == ST_IDLE) || (state_q == ST_ACTIVE));
        if (load_ok) begin
            addr_d  = sr_q;
            cnt_d   = CNT_W'(GUARD_CYCLES - 1);
            state_d = ST_GUARD;
        end else begin
            case (state_q)
                ST_GUARD: begin
                    if (cnt_q == '0) begin
                        if (in_range) begin
                            state_d = ST_RESET;
                            cnt_d   = CNT_W'(RST_CYCLES - 1);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_RESET: begin
                    if (cnt_q == '0) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic: next values of the registered outputs plus the iw broadcast
    always_comb begin
        proj_on = (state_q == ST_RESET) || (state_q == ST_ACTIVE);
        ena_d   = ((state_d == ST_RESET) || (state_d == ST_ACTIVE)) ? sel_onehot : '0;
        busy_d  = (state_d == ST_GUARD) || (state_d == ST_RESET);
        out_d   = proj_on ? sel_ow : '0;
        iw_c    = {bus.uio_in, bus.ui_in,
                   bus.usr_rst_n & (state_q == ST_ACTIVE),
                   bus.usr_clk & proj_on};
    end

    // Shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            ena_q  <= '0;
            busy_q <= 1'b0;
            out_q  <= '0;
        end else begin
            if (bus.sel_shift) begin
                sr_q <= {sr_q[ADDR_W-2:0], bus.sel_data};
            end
            ena_q  <= ena_d;
            busy_q <= busy_d;
            out_q  <= out_d;
        end
    end

    assign bus.iw       = iw_c;
    assign bus.ena      = ena_q;
    assign bus.busy     = busy_q;
    assign bus.cur_addr = addr_q;
    assign bus.uo_out   = out_q[7:0];
    assign bus.uio_out  = out_q[15:8];
    assign bus.uio_oe   = out_q[23:16];

endmodule
